ste_bus_arbiter: RTL

//  Sequences 68000 bus mastership between the CPU and NREQ alternate masters (0=DMA via gstmcu, 1=blitter).

---
 rtl/ste_bus_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ste_bus_arbiter.sv
// 68000 bus-mastership arbiter: runs the BR/BG/BGACK handshake for NREQ alternate
// masters, grants one requester per tenure, bounds tenures and enforces a CPU gap.
module ste_bus_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned RR         = 0,
  parameter int unsigned MAX_TENURE = 64,
  parameter int unsigned CPU_GAP    = 2
) (
  input  logic            clk32,
  input  logic            resb,
  input  logic            clk_en,
  input  logic            as_n,
  input  logic            bg_n,
  input  logic            bgack_n_i,
  input  logic [NREQ-1:0] req_n,
  output logic            br_n,
  output logic            bgack_n_o,
  output logic [NREQ-1:0] gnt_n,
  output logic [NREQ-1:0] yield,
  output logic [1:0]      owner,
  output logic            bus_free
);

  localparam int unsigned   CW   = 8;
  localparam logic [CW-1:0] GAP  = CW'(CPU_GAP);
  localparam logic [CW-1:0] MAXT = CW'(MAX_TENURE);

  typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    rr_ptr;

  logic       pend_c;
  logic       found_c;
  logic [1:0] win_c;
  logic [1:0] win_next_c;
  logic       owner_held_c;
  logic       others_c;

  assign pend_c = |(~req_n);

  // Winner: first low req_n at or above the scan base, then wrap to indices below it.
  always_comb begin : pick_winner
    int unsigned base;
    base    = (RR != 0) ? 32'(rr_ptr) : 32'd0;
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found_c && i >= base && !req_n[i]) begin
        found_c = 1'b1;
        win_c   = 2'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found_c && i < base && !req_n[i]) begin
        found_c = 1'b1;
        win_c   = 2'(i);
      end
    end
  end

  assign win_next_c = (32'(win_c) + 32'd1 >= NREQ) ? 2'd0 : win_c + 2'd1;

  // Owner still holding its request, and whether anyone else is waiting.
  always_comb begin
    owner_held_c = 1'b0;
    others_c     = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (2'(i) == owner) begin
        if (!req_n[i]) owner_held_c = 1'b1;
      end else if (!req_n[i]) begin
        others_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      br_n      <= 1'b1;
      bgack_n_o <= 1'b1;
      gnt_n     <= '1;
      yield     <= '0;
      owner     <= '0;
      bus_free  <= 1'b1;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (cnt < GAP) cnt <= cnt + CW'(1);
          if (pend_c && cnt >= GAP) begin
            state    <= REQ;
            br_n     <= 1'b0;
            bus_free <= 1'b0;
          end
        end
        REQ: begin
          if (!pend_c) begin
            state    <= IDLE;
            br_n     <= 1'b1;
            cnt      <= GAP;
            bus_free <= 1'b1;
          end else if (!bg_n && as_n && bgack_n_i) begin
            state     <= OWN;
            bgack_n_o <= 1'b0;
            br_n      <= 1'b1;
            cnt       <= '0;
            gnt_n     <= ~(NREQ'(1) << win_c);
            owner     <= win_c;
            if (RR != 0) rr_ptr <= win_next_c;
          end
        end
        OWN: begin
          if (cnt < MAXT) cnt <= cnt + CW'(1);
          // Release takes precedence over a same-tick yield.
          if (!owner_held_c) begin
            state <= REL;
            gnt_n <= '1;
            yield <= '0;
          end else if (cnt == MAXT && others_c) begin
            yield <= yield | (NREQ'(1) << owner);
          end
        end
        REL: begin
          state     <= IDLE;
          bgack_n_o <= 1'b1;
          cnt       <= '0;
          bus_free  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
